sf_stream_reader: RTL and testbench
===================================

# sf_stream_reader

Read-side consumer for the team's 8-bit synchronous FIFO. It pops words through the FIFO's `r_en`/`empty`/`data_out` port and absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer. It re-presents the words on a downstream valid/ready stream. It sits between the FIFO and any stream sink, and is the reader counterpart to the existing FIFO write-side driver.

## Interface
Parameters:
- `DATA_W`, default 8: word width; must match the FIFO's `data_out`.
- `CNT_W`, default 16: width of the `words_out` transfer counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: permits new FIFO reads; does not stop the drain of buffered words.
- `flush` in 1: synchronous discard of buffered and in-flight words.
- `empty` in 1: FIFO empty flag.
- `data_out` in DATA_W: FIFO read data, valid the cycle after `r_en`.
- `r_en` out 1: FIFO read strobe.
- `m_valid` out 1: downstream word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DATA_W: downstream word.
- `words_out` out CNT_W: count of accepted transfers; wraps.
- `busy` out 1: high when the buffer is occupied or a read is in flight.

## Operation
State registers:
- `occ`: buffer occupancy, 0..3.
- `infl`: 1 = a read was issued last cycle.
- `discard`: 1 = drop the word arriving this cycle.
- 3-entry circular buffer with 2-bit `rd_ptr` and `wr_ptr`. Each pointer wraps from 2 to 0.

Read issue (combinational from registers and inputs):
- `r_en = en & ~empty & ~flush & ~rst & (occ + infl < 3)`.
- No combinational path exists from `m_ready` to `r_en`.
- `r_en` is never asserted while `empty` = 1, so the block never underflows the FIFO.

Capture:
- If `infl` = 1 and `discard` = 0, `data_out` is written at `wr_ptr` at the clock edge, and `wr_ptr` advances.
- If `infl` = 1 and `discard` = 1, `data_out` is ignored.
- Next `infl` = `r_en`.

Output:
- `m_valid = (occ != 0)`.
- `m_data` = `buf[rd_ptr]`; it is 0 when `occ` = 0.
- A transfer is `m_valid & m_ready`. On a transfer, `rd_ptr` advances and `words_out` increments mod 2^CNT_W.
- `occ` next = `occ` + capture − transfer. Simultaneous capture and transfer leave `occ` unchanged.
- Ordering is strict FIFO order, with no duplication or loss except on `flush`.

Flush:
- In the cycle `flush` = 1, `occ`, `rd_ptr` and `wr_ptr` go to 0, and no transfer is counted even if `m_ready` = 1.
- If a read is in flight (`infl` = 1), `discard` is set so that the next-arriving word is dropped.
- `r_en` is held low during `flush`.
- `words_out` is not cleared by `flush`.

`en` low:
- No new reads are issued.
- Any in-flight word is still captured, and the buffer keeps draining normally.

Reset:
- Applied asynchronously while `rst` = 1.
- Values during reset: `r_en`=0, `m_valid`=0, `m_data`=0, `words_out`=0, `busy`=0, `occ`=0, `infl`=0, `discard`=0, both pointers 0.
- Reset in the middle of a read drops the in-flight word; after release, `infl` = 0, so the returning FIFO data is never captured.

## Timing
- Latency from FIFO to stream: `r_en` high in cycle N, `data_out` valid in N+1 and captured at the end of N+1, `m_valid` high in N+2.
- Throughput: with `m_ready` held at 1 and the FIFO never empty, one word per cycle is sustained from cycle N+2 onward.
- Backpressure: with `m_ready` = 0, at most 3 words are read before `r_en` drops.
  - With a prefilled FIFO and `en` rising in cycle 0, `r_en` is high in cycles 0, 1 and 2 and low from cycle 3, and `occ` reaches 3 at the end of cycle 3.
- Recovery: the first `m_ready` = 1 cycle after a stall re-enables `r_en` in the following cycle.
- Valid/ready rule: `m_valid` never drops without a transfer or `flush`, and `m_data` is stable while `m_valid & ~m_ready`.
- `busy = (occ != 0) | infl`, registered-derived, with no input combinational path.

## Test plan
- **Reset values:** assert `rst` mid-cycle with `occ` = 2 and `infl` = 1. All outputs go to 0 immediately; after release, no capture and `m_valid` stays 0 until a new read.
- **Streaming:** FIFO preloaded with 0x01..0x10, `en` = 1, `m_ready` = 1. `r_en` is high in cycles 0–15, `m_data` = 0x01..0x10 in cycles 2–17, and `words_out` = 16.
- **Backpressure:** 8 words preloaded, `m_ready` = 0 for 10 cycles then 1. Exactly 3 reads occur, `m_data` holds 0x01, and after release all 8 words arrive in order with no gap after the first refill.
- **Empty boundary:** FIFO toggles empty every other cycle. `r_en` is never high while `empty` = 1, and the output order is preserved.
- **Flush:** `flush` is pulsed with `occ` = 2 and `infl` = 1. `m_valid` = 0 the next cycle, the arriving word is dropped, the next read delivers the following FIFO word, and `words_out` is unchanged by the flush.
- **Counter wrap:** with `CNT_W` = 4, 17 transfers give `words_out` = 1.

Source files
------------

// File: rtl/sf_stream_reader.sv
// Read-side consumer for the 8-bit synchronous FIFO: pops words, hides the FIFO's
// one-cycle read latency in a 3-entry skid buffer, and re-presents them as a valid/ready stream.
module sf_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_out,
    output logic              r_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  words_out,
    output logic              busy
);

    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic              infl;
    logic              discard;
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic [DATA_W-1:0] buf_mem [3];
    logic              capture;
    logic              xfer;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for every word already in flight so the buffer can never overflow.
    assign r_en    = en & ~empty & ~flush & ~rst & (({1'b0, occ} + {2'b00, infl}) < 3'd3);
    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
    assign busy    = m_valid | infl;
    assign xfer    = m_valid & m_ready & ~flush;
    assign capture = infl & ~discard & ~flush;

    always_comb begin
        occ_next = occ;
        if (flush)
            occ_next = 2'd0;
        else if (capture & ~xfer)
            occ_next = occ + 2'd1;
        else if (xfer & ~capture)
            occ_next = occ - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= 2'd0;
            infl      <= 1'b0;
            discard   <= 1'b0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            words_out <= '0;
        end else begin
            occ     <= occ_next;
            infl    <= r_en;
            discard <= flush & infl;
            if (flush) begin
                rd_ptr <= 2'd0;
                wr_ptr <= 2'd0;
            end else begin
                if (capture)
                    wr_ptr <= next_ptr(wr_ptr);
                if (xfer)
                    rd_ptr <= next_ptr(rd_ptr);
            end
            if (xfer)
                words_out <= words_out + CNT_W'(1);
        end
    end

    // Storage needs no reset: m_data is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture)
            buf_mem[wr_ptr] <= data_out;
    end

endmodule

// File: tb/tb_sf_stream_reader.sv
// Scoreboard bench for sf_stream_reader: a FIFO model feeds the DUT, stimulus queues the
// expected words, and a negedge monitor checks every handshake against that queue.
module tb_sf_stream_reader;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              flush;
    logic              empty;
    logic              hide_empty;
    logic [DATA_W-1:0] data_out;
    logic              r_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  words_out;
    logic              busy;

    logic [7:0]  fifo_mem [0:4095];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic [7:0]  exp_q [$];
    int          accounted = 0;
    int          exp_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic        hold_pending = 1'b0;
    logic [7:0]  hold_data = '0;

    sf_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .empty(empty),
        .data_out(data_out), .r_en(r_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .words_out(words_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, one pop per r_en.
    assign empty = (fifo_rd == fifo_wr) | hide_empty;
    always @(posedge clk) begin
        if (r_en) begin
            data_out <= fifo_mem[fifo_rd % 4096];
            fifo_rd  <= fifo_rd + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic rdy, input logic fl, input logic he);
        en         = e;
        m_ready    = rdy;
        flush      = fl;
        hide_empty = he;
    endtask

    task automatic pushWord(input logic [7:0] v);
        fifo_mem[fifo_wr % 4096] = v;
        fifo_wr++;
        exp_q.push_back(v);
    endtask

    // Words popped from the FIFO but not yet delivered are lost on flush or reset.
    task automatic dropUndelivered();
        while (accounted < fifo_rd) begin
            if (exp_q.size() > 0)
                void'(exp_q.pop_front());
            accounted++;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_r_en", r_en, 0);
            checkOutput("rst_m_valid", m_valid, 0);
            checkOutput("rst_m_data", m_data, 0);
            checkOutput("rst_words_out", words_out, 0);
            checkOutput("rst_busy", busy, 0);
            dropUndelivered();
            exp_cnt      = 0;
            hold_pending = 1'b0;
        end else begin
            checkOutput("no_underflow", r_en & empty, 0);
            checkOutput("words_out", words_out, exp_cnt % (1 << CNT_W));
            if (!m_valid)
                checkOutput("idle_data", m_data, 0);
            if (hold_pending) begin
                checkOutput("hold_valid", m_valid, 1);
                checkOutput("hold_data", m_data, hold_data);
            end
            hold_pending = 1'b0;
            if (flush) begin
                dropUndelivered();
            end else if (m_valid && m_ready) begin
                if (exp_q.size() == 0)
                    checkOutput("extra_word", 1, 0);
                else
                    checkOutput("data", m_data, exp_q.pop_front());
                accounted++;
                exp_cnt++;
            end else if (m_valid) begin
                hold_pending = 1'b1;
                hold_data    = m_data;
            end
        end
    end

    initial begin
        int reads;
        int waited;
        rst = 1'b0;
        data_out = '0;
        applyStimulus(0, 0, 0, 0);
        #1 rst = 1'b1;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Streaming: 16 words, one per cycle after a two-cycle latency.
        for (int i = 1; i <= 16; i++) pushWord(8'(i));
        tick();
        applyStimulus(1, 1, 0, 0);
        for (int c = 0; c < 20; c++) begin
            #1;
            checkOutput("stream_r_en", r_en, (c < 16) ? 1 : 0);
            if (c == 1) checkOutput("stream_latency", m_valid, 0);
            if (c >= 2 && c < 18) checkOutput("stream_data", m_data, c - 1);
            tick();
        end
        checkOutput("stream_count_wrap", words_out, 0);

        // Backpressure: at most 3 reads while stalled, then gap-free drain.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) pushWord(8'(8'h21 + i));
        tick();
        applyStimulus(1, 0, 0, 0);
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (r_en) reads++;
            tick();
        end
        checkOutput("bp_reads", reads, 3);
        checkOutput("bp_hold_data", m_data, 8'h21);
        applyStimulus(1, 1, 0, 0);
        for (int c = 10; c < 19; c++) begin
            #1;
            if (c == 10) checkOutput("bp_r_en_still_low", r_en, 0);
            if (c == 11) checkOutput("bp_recover_r_en", r_en, 1);
            if (c == 11) checkOutput("counter_wrap_17", words_out, 1);
            if (c < 18) begin
                checkOutput("bp_no_gap", m_valid, 1);
                checkOutput("bp_order", m_data, 8'h21 + (c - 10));
            end else begin
                checkOutput("bp_done", m_valid, 0);
            end
            tick();
        end

        // Asynchronous reset with two words buffered and one in flight.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) pushWord(8'(8'h31 + i));
        tick();
        applyStimulus(1, 0, 0, 0);
        repeat (3) tick();
        #1;
        checkOutput("pre_rst_busy", busy, 1);
        checkOutput("pre_rst_valid", m_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", m_valid, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_count", words_out, 0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(0, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("post_rst_valid", m_valid, 0);
            checkOutput("post_rst_busy", busy, 0);
            tick();
        end
        applyStimulus(1, 1, 0, 0);
        repeat (5) tick();
        checkOutput("post_rst_count", words_out, 1);

        // Flush with two words buffered and one in flight.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) pushWord(8'(8'h41 + i));
        tick();
        applyStimulus(1, 0, 0, 0);
        repeat (3) tick();
        applyStimulus(1, 1, 1, 0);
        #1;
        checkOutput("flush_r_en", r_en, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        #1;
        checkOutput("flush_valid", m_valid, 0);
        checkOutput("flush_count", words_out, 1);
        tick();
        tick();
        #1;
        checkOutput("flush_next_word", m_data, 8'h44);
        applyStimulus(1, 1, 0, 0);
        repeat (12) tick();

        // Empty flag toggling every cycle.
        for (int i = 0; i < 10; i++) pushWord(8'(8'h51 + i));
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1, 1, 0, c[0]);
            tick();
        end

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 1) == 0) pushWord(8'($urandom));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
            tick();
        end

        applyStimulus(1, 1, 0, 0);
        waited = 0;
        while ((exp_q.size() != 0 || fifo_rd != fifo_wr || busy) && waited < 400) begin
            tick();
            waited++;
        end
        checkOutput("drain_timeout", (waited < 400) ? 1 : 0, 1);
        checkOutput("drain_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
